// File: rtl/fp16_log_addr_stage.sv
// fp16_log_addr_stage
//   Address stage in front of the 256-entry FP16 log-mantissa LUT. Each FP16
//   operand is split into a signed unbiased exponent and a LUT address formed
//   from the top mantissa bits. The address is registered and driven to the
//   LUT (S1). The LUT's combinational result is then captured together with
//   the exponent and the class flags (S2). The stage sustains one operand per
//   clock, with valid/ready on both sides.
//
//   Build option: define LOG_ADDR_ROUND_EN to round the LUT address half-up.
//   A carry out of the address renormalises the exponent. Without the macro
//   the address is truncated.
//
// Ports
//   clk        in   1          rising-edge clock
//   reset      in   1          asynchronous, active-high
//   in_valid   in   1          input operand valid
//   in_ready   out  1          stage can accept an operand
//   in_data    in   DWIDTH     FP16 operand
//   lut_addr   out  ADDR_W     registered LUT address
//   lut_log    in   DWIDTH     LUT data for lut_addr (same cycle)
//   out_valid  out  1          result valid
//   out_ready  in   1          downstream accepts result
//   out_exp    out  EXPONENT+1 signed unbiased exponent
//   out_log    out  DWIDTH     captured LUT value
//   out_flags  out  4          {neg, zero, inf, nan}
module fp16_log_addr_stage #(
   parameter int unsigned DWIDTH   = 16,
   parameter int unsigned EXPONENT = 5,
   parameter int unsigned MANTISSA = 10,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned BIAS     = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DWIDTH-1:0]   in_data,
   output logic [ADDR_W-1:0]   lut_addr,
   input  logic [DWIDTH-1:0]   lut_log,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [EXPONENT:0]   out_exp,
   output logic [DWIDTH-1:0]   out_log,
   output logic [3:0]          out_flags
);

   localparam logic [EXPONENT-1:0] EXP_MAX = '1;

   // Field decode
   logic                sgn;
   logic [EXPONENT-1:0] exp_f;
   logic [ADDR_W-1:0]   man_hi;
   logic                man_nz;
   logic [EXPONENT:0]   exp_unb;
   logic                is_zero, is_inf, is_nan;
   logic [ADDR_W-1:0]   dec_addr;
   logic [EXPONENT:0]   dec_exp;
   logic [3:0]          dec_flags;
`ifdef LOG_ADDR_ROUND_EN
   logic                rnd_bit;
   logic [ADDR_W:0]     addr_sum;
`endif

   // Pipeline state
   logic                s1_valid_q, s1_valid_d;
   logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
   logic [EXPONENT:0]   s1_exp_q, s1_exp_d;
   logic [3:0]          s1_flags_q, s1_flags_d;
   logic                out_valid_q, out_valid_d;
   logic [EXPONENT:0]   out_exp_q, out_exp_d;
   logic [DWIDTH-1:0]   out_log_q, out_log_d;
   logic [3:0]          out_flags_q, out_flags_d;

   logic                in_fire;
   logic                s2_load;

   always_comb begin
      sgn     = in_data[DWIDTH-1];
      exp_f   = in_data[DWIDTH-2 -: EXPONENT];
      man_hi  = in_data[MANTISSA-1 -: ADDR_W];
      man_nz  = |in_data[MANTISSA-1:0];
      exp_unb = {1'b0, exp_f} - (EXPONENT+1)'(BIAS);
      is_zero = (exp_f == '0);
      is_inf  = (exp_f == EXP_MAX) && !man_nz;
      is_nan  = (exp_f == EXP_MAX) && man_nz;

`ifdef LOG_ADDR_ROUND_EN
      // Round half up. A carry out means the mantissa rounded to 2.0, so the
      // address wraps to 0 and the exponent goes up by one.
      rnd_bit  = in_data[MANTISSA-ADDR_W-1];
      addr_sum = {1'b0, man_hi} + (ADDR_W+1)'(rnd_bit);
      dec_addr = addr_sum[ADDR_W-1:0];
      dec_exp  = exp_unb + (EXPONENT+1)'(addr_sum[ADDR_W]);
`else
      dec_addr = man_hi;
      dec_exp  = exp_unb;
`endif

      // Zero/denormal, inf and nan all present address 0 and exponent 0.
      if (is_zero || is_inf || is_nan) begin
         dec_addr = '0;
         dec_exp  = '0;
      end
      dec_flags = {sgn, is_zero, is_inf, is_nan};
   end

   // Handshake. A held output blocks S1 only when S1 is also occupied.
   always_comb begin
      in_ready = !s1_valid_q || !out_valid_q || out_ready;
      in_fire  = in_valid && in_ready;
      s2_load  = s1_valid_q && (!out_valid_q || out_ready);

      s1_valid_d  = in_fire ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
      s1_addr_d   = in_fire ? dec_addr  : s1_addr_q;
      s1_exp_d    = in_fire ? dec_exp   : s1_exp_q;
      s1_flags_d  = in_fire ? dec_flags : s1_flags_q;

      out_valid_d = s2_load || (out_valid_q && !out_ready);
      out_exp_d   = s2_load ? s1_exp_q   : out_exp_q;
      out_log_d   = s2_load ? lut_log    : out_log_q;
      out_flags_d = s2_load ? s1_flags_q : out_flags_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_addr_q   <= '0;
         s1_exp_q    <= '0;
         s1_flags_q  <= '0;
         out_valid_q <= 1'b0;
         out_exp_q   <= '0;
         out_log_q   <= '0;
         out_flags_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_addr_q   <= s1_addr_d;
         s1_exp_q    <= s1_exp_d;
         s1_flags_q  <= s1_flags_d;
         out_valid_q <= out_valid_d;
         out_exp_q   <= out_exp_d;
         out_log_q   <= out_log_d;
         out_flags_q <= out_flags_d;
      end
   end

   assign lut_addr  = s1_addr_q;
   assign out_valid = out_valid_q;
   assign out_exp   = out_exp_q;
   assign out_log   = out_log_q;
   assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp16_log_addr_stage.sv
// tb_fp16_log_addr_stage
//   Directed bench for fp16_log_addr_stage. A small combinational LUT stand-in
//   answers lut_addr. Expected values are hand-derived FP16 decodes. The
//   rounding-dependent values switch on LOG_ADDR_ROUND_EN.
module tb_fp16_log_addr_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [7:0]  lut_addr;
   logic [15:0] lut_log;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_exp;
   logic [15:0] out_log;
   logic [3:0]  out_flags;

   int tests = 0;
   int fails = 0;

`ifdef LOG_ADDR_ROUND_EN
   localparam logic [7:0] A_3FFF = 8'h00;  localparam logic [5:0] E_3FFF = 6'h01;
   localparam logic [7:0] A_7BFF = 8'h00;  localparam logic [5:0] E_7BFF = 6'h10;
   localparam logic [7:0] A_4A06 = 8'h82;
`else
   localparam logic [7:0] A_3FFF = 8'hFF;  localparam logic [5:0] E_3FFF = 6'h00;
   localparam logic [7:0] A_7BFF = 8'hFF;  localparam logic [5:0] E_7BFF = 6'h0F;
   localparam logic [7:0] A_4A06 = 8'h81;
`endif

   fp16_log_addr_stage #(
      .DWIDTH(16), .EXPONENT(5), .MANTISSA(10), .ADDR_W(8), .BIAS(15)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .lut_addr(lut_addr), .lut_log(lut_log),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_exp(out_exp), .out_log(out_log), .out_flags(out_flags)
   );

   always #5 clk = ~clk;

   // LUT stand-in: zero at address 0, distinct elsewhere.
   function automatic logic [15:0] lut_fn(input logic [7:0] a);
      return {a[6:0], 1'b0, a};
   endfunction
   assign lut_log = lut_fn(lut_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [5:0] e, input logic [7:0] a,
                          input logic [3:0] f);
      chk({tag, ".ov"},    32'(out_valid), 32'd1);
      chk({tag, ".exp"},   32'(out_exp),   32'(e));
      chk({tag, ".log"},   32'(out_log),   32'(lut_fn(a)));
      chk({tag, ".flags"}, 32'(out_flags), 32'(f));
   endtask

   // One operand through an idle pipeline with out_ready high.
   task automatic single(input string tag, input logic [15:0] d, input logic [7:0] a,
                         input logic [5:0] e, input logic [3:0] f);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
      chk({tag, ".addr"}, 32'(lut_addr), 32'(a));
      chk({tag, ".ov0"},  32'(out_valid), 32'd0);
      tick();
      chk_out(tag, e, a, f);
      tick();
      chk({tag, ".drain"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      #2;
      chk("rst.ov",    32'(out_valid), 32'd0);
      chk("rst.addr",  32'(lut_addr),  32'd0);
      chk("rst.exp",   32'(out_exp),   32'd0);
      chk("rst.log",   32'(out_log),   32'd0);
      chk("rst.flags", 32'(out_flags), 32'd0);
      tick();
      reset = 1'b0;
      #1;
      chk("rst.ready", 32'(in_ready), 32'd1);

      // T1, T3 and assorted normals
      single("t1_3c00", 16'h3C00, 8'h00, 6'h00, 4'b0000);
      single("t3_3fff", 16'h3FFF, A_3FFF, E_3FFF, 4'b0000);
      single("t3_7bff", 16'h7BFF, A_7BFF, E_7BFF, 4'b0000);
      single("fbff",    16'hFBFF, A_7BFF, E_7BFF, 4'b1000);
      single("4a06",    16'h4A06, A_4A06, 6'h03, 4'b0000);
      single("0400",    16'h0400, 8'h00, 6'h32, 4'b0000);

      // T4 specials, each preceded by a nonzero address so addr=0 is visible
      single("pre1",    16'h3E00, 8'h80, 6'h00, 4'b0000);
      single("t4_0000", 16'h0000, 8'h00, 6'h00, 4'b0100);
      single("t4_8000", 16'h8000, 8'h00, 6'h00, 4'b1100);
      single("pre2",    16'h4A06, A_4A06, 6'h03, 4'b0000);
      single("t4_0001", 16'h0001, 8'h00, 6'h00, 4'b0100);
      single("t4_7c00", 16'h7C00, 8'h00, 6'h00, 4'b0010);
      single("pre3",    16'hBA00, 8'h80, 6'h3F, 4'b1000);
      single("t4_7e00", 16'h7E00, 8'h00, 6'h00, 4'b0001);
      single("fc00",    16'hFC00, 8'h00, 6'h00, 4'b1010);
      single("fe00",    16'hFE00, 8'h00, 6'h00, 4'b1001);

      // T2 back-to-back
      in_valid = 1'b1;
      in_data  = 16'h3E00;
      tick();
      chk("t2.addr0", 32'(lut_addr), 32'h80);
      in_data = 16'hBA00;
      tick();
      in_valid = 1'b0;
      chk("t2.addr1", 32'(lut_addr), 32'h80);
      chk_out("t2.r0", 6'h00, 8'h80, 4'b0000);
      tick();
      chk_out("t2.r1", 6'h3F, 8'h80, 4'b1000);
      tick();
      chk("t2.drain", 32'(out_valid), 32'd0);

      // T5 stall with out_ready low for 6 cycles
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h4A06;
      #1;
      chk("t5.rdy0", 32'(in_ready), 32'd1);
      tick();
      in_data = 16'hBA00;
      chk("t5.rdy1", 32'(in_ready), 32'd1);
      tick();
      in_data = 16'h0400;
      chk("t5.rdy2", 32'(in_ready), 32'd0);
      chk_out("t5.hold0", 6'h03, A_4A06, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t5.rdyh", 32'(in_ready), 32'd0);
         chk_out("t5.hold", 6'h03, A_4A06, 4'b0000);
      end
      out_ready = 1'b1;
      #1;
      chk("t5.rdyrel", 32'(in_ready), 32'd1);
      tick();
      in_data = 16'h3FFF;
      chk_out("t5.b", 6'h3F, 8'h80, 4'b1000);
      tick();
      in_valid = 1'b0;
      chk_out("t5.c", 6'h32, 8'h00, 4'b0000);
      tick();
      chk_out("t5.d", E_3FFF, A_3FFF, 4'b0000);
      tick();
      chk("t5.drain", 32'(out_valid), 32'd0);

      // T6 reset with two operands in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h3E00;
      tick();
      in_data = 16'h4A06;
      tick();
      in_valid = 1'b0;
      chk("t6.pre", 32'(out_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk("t6.ov",    32'(out_valid), 32'd0);
      chk("t6.addr",  32'(lut_addr),  32'd0);
      chk("t6.exp",   32'(out_exp),   32'd0);
      chk("t6.log",   32'(out_log),   32'd0);
      chk("t6.flags", 32'(out_flags), 32'd0);
      tick();
      reset     = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("t6.rdy", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6.idle", 32'(out_valid), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
